// File: rtl/keypad_scanner.sv
// keypad_scanner: scans and debounces a 4x4 PmodKYPD matrix, emitting a hex key code and a stretched strobe
//
// Ports:
//   clk        system clock (single domain)
//   rst_n      asynchronous active-low reset
//   row_n[3:0] keypad rows, active-low, asynchronous (bit 3 = top row)
//   col_n[3:0] column drive, active-low, one bit low at a time
//   key_code   hex value of the last accepted key
//   key_strobe high PULSE_CYCLES cycles per accepted press
//   key_down   a debounced key is currently held
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int PULSE_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic       key_down
);
    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    // nibble i is the key at column i/4, row bit i%4 (row bit 3 = top)
    localparam logic [63:0] KEYMAP = 64'hABCD_369E_258F_1470;

    typedef enum logic [1:0] {K_NONE, K_SINGLE, K_MULTI} kind_t;
    typedef enum logic {RELEASED, PRESSED} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [1:0]    col_idx;
    logic [DW-1:0] dwell;
    logic [11:0]   acc;
    kind_t         cand_kind, kind;
    logic [3:0]    cand_code, code, hit;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PW-1:0] pcnt;
    logic [15:0]   frame;
    logic [4:0]    ones;
    logic          last, frame_end, same, stable, accept, release_ev;
    state_t        state, state_nx;

    assign last      = dwell == DW'(SCAN_CYCLES - 1);
    assign frame_end = last && col_idx == 2'd3;

    // Column 3 is classified straight from the synchronizer in the frame-end cycle.
    always_comb begin
        frame = {~row_s2, acc};
        ones  = '0;
        hit   = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                ones = ones + 5'd1;
                hit  = KEYMAP[i*4 +: 4];
            end
        end
        kind = ones == 5'd0 ? K_NONE : ones == 5'd1 ? K_SINGLE : K_MULTI;
        code = kind == K_SINGLE ? hit : 4'h0;
    end

    always_comb begin
        same       = kind == cand_kind && code == cand_code;
        cnt_nx     = kind == K_MULTI ? '0 : !same ? CW'(1) :
                     cnt == CW'(DEBOUNCE_FRAMES) ? cnt : cnt + 1'b1;
        stable     = frame_end && cnt_nx == CW'(DEBOUNCE_FRAMES);
        accept     = stable && kind == K_SINGLE && (state == RELEASED || code != key_code);
        release_ev = stable && kind == K_NONE && state == PRESSED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            col_idx   <= '0;
            dwell     <= '0;
            acc       <= '0;
            cand_kind <= K_NONE;
            cand_code <= '0;
            cnt       <= '0;
            key_code  <= '0;
            pcnt      <= '0;
        end else begin
            row_s1  <= row_n;
            row_s2  <= row_s1;
            dwell   <= last ? '0 : dwell + 1'b1;
            col_idx <= last ? col_idx + 2'd1 : col_idx;
            if (last && !frame_end)
                acc[col_idx*4 +: 4] <= ~row_s2;
            if (frame_end) begin
                cand_kind <= kind;
                cand_code <= code;
                cnt       <= cnt_nx;
            end
            key_code <= accept ? code : key_code;
            // reloading while high restarts the pulse without a new rising edge
            pcnt     <= accept ? PW'(PULSE_CYCLES) : pcnt != '0 ? pcnt - 1'b1 : pcnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RELEASED;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = accept ? PRESSED : release_ev ? RELEASED : state;
    end

    always_comb begin
        key_down   = state == PRESSED;
        key_strobe = pcnt != '0;
        col_n      = ~(4'b1000 >> col_idx);
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan rotation, debounce, acceptance and reset abort
module tb_keypad_scanner;
    // key positions: column*4 + row bit (row bit 3 = top row)
    localparam int K1 = 3, K7 = 1, K5 = 6, KE = 8, KD = 12, KA = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n, col_n, key_code;
    logic        key_strobe, key_down;
    logic [15:0] keys = '0;
    int          tests = 0, fails = 0;
    int          rises = 0, cur_w = 0, last_w = 0, r0;
    logic        prev_s = 1'b0;
    logic [3:0]  col_seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_FRAMES(3), .PULSE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_strobe(key_strobe), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[3-c] && keys[c*4+r]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_strobe && !prev_s) rises++;
        if (key_strobe) cur_w++;
        else if (prev_s) begin
            last_w = cur_w;
            cur_w  = 0;
        end
        prev_s = key_strobe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst col_n", col_n, 4'b0111);
        check("rst code", key_code, 4'h0);
        check("rst strobe", key_strobe, 1'b0);
        check("rst down", key_down, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("col step %0d", k), col_n, col_seq[k % 4]);
            repeat (4) @(negedge clk);
        end

        r0 = rises;
        keys = 16'(1) << K5;
        frames(5);
        check("5 strobes", rises - r0, 1);
        check("5 width", last_w, 2);
        check("5 code", key_code, 4'h5);
        check("5 down", key_down, 1'b1);
        keys = '0;
        frames(4);
        check("5 rel down", key_down, 1'b0);
        check("5 rel code", key_code, 4'h5);
        check("5 rel strobes", rises - r0, 1);

        r0 = rises;
        for (int k = 0; k < 6; k++) begin
            keys = (k % 2 == 0) ? 16'(1) << KA : '0;
            frames(1);
        end
        check("bounce quiet", rises - r0, 0);
        keys = 16'(1) << KA;
        frames(2);
        check("A early", rises - r0, 0);
        frames(2);
        check("A strobes", rises - r0, 1);
        check("A code", key_code, 4'hA);
        keys = '0;
        frames(4);

        r0 = rises;
        keys = (16'(1) << K1) | (16'(1) << KD);
        frames(5);
        check("multi quiet", rises - r0, 0);
        check("multi down", key_down, 1'b0);
        keys = 16'(1) << K1;
        frames(4);
        check("1 strobes", rises - r0, 1);
        check("1 code", key_code, 4'h1);

        r0 = rises;
        keys = 16'(1) << K7;
        frames(4);
        check("7 strobes", rises - r0, 1);
        check("7 code", key_code, 4'h7);
        keys = 16'(1) << KE;
        frames(4);
        check("E strobes", rises - r0, 2);
        check("E code", key_code, 4'hE);
        check("E down", key_down, 1'b1);
        frames(10);
        check("E no repeat", rises - r0, 2);
        keys = '0;
        frames(4);
        check("E rel down", key_down, 1'b0);

        keys = 16'(1) << K5;
        frames(3);
        check("mid strobe high", key_strobe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort strobe", key_strobe, 1'b0);
        check("abort down", key_down, 1'b0);
        check("abort code", key_code, 4'h0);
        check("abort col_n", col_n, 4'b0111);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rises;
        frames(2);
        check("post rst quiet", rises - r0, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid deb down", key_down, 1'b0);
        check("mid deb strobe", key_strobe, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        frames(2);
        check("fresh quiet", rises - r0, 0);
        frames(2);
        check("fresh strobes", rises - r0, 1);
        check("fresh code", key_code, 4'h5);
        check("fresh down", key_down, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the seven-segment display controller. Scans the 4x4 PmodKYPD matrix and debounces it.
- Emits a 4-bit hex key code plus a stretched strobe. The display controller samples the code on the strobe's rising edge and shifts the new digit into its 4-digit buffer.
- One strobe per debounced key press. No auto-repeat.

Parameters:
- SCAN_CYCLES, 100000: clk cycles each column is driven low (1 ms at 100 MHz). Minimum 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-matrix frames needed to accept a press or a release. Minimum 1.
- PULSE_CYCLES, 8: width of key_strobe in clk cycles. Minimum 1.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- row_n  in  4  keypad rows, active-low, pulled up, asynchronous to clk. Bit 3 is the top row.
- col_n  out 4  keypad column drive, active-low, exactly one bit low at a time.
- key_code  out 4  hex value of the last accepted key.
- key_strobe  out 1  high for PULSE_CYCLES cycles per accepted press. Feeds the display controller's update input.
- key_down  out 1  level: a debounced key is currently held.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - col_n=4'b0111, column index 0, dwell counter 0
  - frame accumulator cleared, debounce counter 0, candidate=NONE, state RELEASED
  - key_code=4'h0, key_strobe=0, key_down=0
- Reset asserted mid-scan or mid-pulse aborts everything immediately. No strobe may appear after reset release until a new full debounce completes.
- Synchronizer: row_n passes through a 2-FF synchronizer before any use.
- Column rotation:
  - col_n sequence 0111 -> 1011 -> 1101 -> 1110 -> 0111 ...
  - Each column is held SCAN_CYCLES cycles, then advances. This wrap-around is continuous.
  - Synchronized rows are sampled on the last dwell cycle of each column.
- Keymap, column then rows top to bottom:
  - col0 (col_n 0111): 1, 4, 7, 0
  - col1 (col_n 1011): 2, 5, 8, F
  - col2 (col_n 1101): 3, 6, 9, E
  - col3 (col_n 1110): A, B, C, D
- Frame classification, done at the end of col3's dwell (one frame = 4*SCAN_CYCLES cycles):
  - NONE: zero active rows across all four columns.
  - SINGLE(code): exactly one active row-bit across all four columns.
  - MULTI: two or more active row-bits.
- Debounce:
  - Result equal to candidate: increment counter, saturating at DEBOUNCE_FRAMES.
  - Result different: candidate=result, counter=1.
  - MULTI always sets counter=0 and takes no action. key_down and key_code hold.
- Acceptance, evaluated in the frame-end cycle once the counter reaches DEBOUNCE_FRAMES:
  - SINGLE(c), and state RELEASED or state PRESSED with a different code:
    - key_code<=c, key_down<=1, state PRESSED.
    - key_strobe rises the next cycle and stays high exactly PULSE_CYCLES cycles.
  - SINGLE(c) equal to the current code while PRESSED: no action (no repeat).
  - NONE while PRESSED: key_down<=0, state RELEASED. key_code holds and no strobe is issued.
- Latency: from row change to strobe is at most (DEBOUNCE_FRAMES+1) frames + 3 cycles.
- Strobe restart: a new acceptance while key_strobe is high restarts the pulse counter. The strobe stays high and ends PULSE_CYCLES after the restart, so no extra rising edge occurs.
- Rolling press: a direct change from one stable single key to another, with no NONE frames between, produces a strobe for the new key.

Test Plan:
- Reset check: bench params SCAN_CYCLES=4, DEBOUNCE_FRAMES=3, PULSE_CYCLES=2. Hold rst_n=0 -> col_n=0111, key_code=0, key_strobe=0, key_down=0. Release -> col_n steps 0111/1011/1101/1110 every 4 cycles and wraps.
- Single press: model the '5' press, row_n bit 2 low only while col_n=1011, held 5 frames -> one key_strobe pulse of exactly 2 cycles, key_code=4'h5, key_down=1. Release for 4 frames -> key_down=0, key_code stays 5, no strobe.
- Bounce: toggle the 'A' contact every frame for 6 frames, then hold -> no strobe during the toggling. Exactly one strobe with key_code=4'hA, 3 frames after the stable hold begins.
- Multiple keys: hold '1' and 'D' together -> no strobe, key_down unchanged. Release 'D' and keep '1' for 3 frames -> strobe, key_code=4'h1.
- Rolling press: hold '7' (strobe, code 7), then switch directly to 'E' -> second strobe, key_code=4'hE, key_down stays 1. Also run a 10-frame hold with no repeat strobes.
- Reset mid-operation: assert rst_n low during the strobe and again mid-debounce -> outputs return to reset values at once. No strobe follows until 3 fresh stable frames.
